// File: rtl/cs_address_sequencer_if.sv
// Sequencer bus: branch-logic inputs toward the sequencer, registered microPC and status back.
interface cs_address_sequencer_if #(
    parameter int unsigned CS_ADDRESS_SEQUENCER_ADDR = 11,
    parameter int unsigned CS_ADDRESS_SEQUENCER_TIPO = 2,
    parameter int unsigned CS_ADDRESS_SEQUENCER_IR   = 32
);
    logic [CS_ADDRESS_SEQUENCER_TIPO-1:0] CS_ADDRESS_SEQUENCER_Tipo_InBus;
    logic [CS_ADDRESS_SEQUENCER_ADDR-1:0] CS_ADDRESS_SEQUENCER_JumpAddr_InBus;
    logic [CS_ADDRESS_SEQUENCER_IR-1:0]   CS_ADDRESS_SEQUENCER_IR_InBus;
    logic                                 CS_ADDRESS_SEQUENCER_Stall_In;
    logic [CS_ADDRESS_SEQUENCER_ADDR-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus;
    logic                                 CS_ADDRESS_SEQUENCER_Valid_Out;
    logic                                 CS_ADDRESS_SEQUENCER_Halt_Out;

    modport master (
        output CS_ADDRESS_SEQUENCER_Tipo_InBus,
        output CS_ADDRESS_SEQUENCER_JumpAddr_InBus,
        output CS_ADDRESS_SEQUENCER_IR_InBus,
        output CS_ADDRESS_SEQUENCER_Stall_In,
        input  CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
        input  CS_ADDRESS_SEQUENCER_Valid_Out,
        input  CS_ADDRESS_SEQUENCER_Halt_Out
    );

    modport slave (
        input  CS_ADDRESS_SEQUENCER_Tipo_InBus,
        input  CS_ADDRESS_SEQUENCER_JumpAddr_InBus,
        input  CS_ADDRESS_SEQUENCER_IR_InBus,
        input  CS_ADDRESS_SEQUENCER_Stall_In,
        output CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
        output CS_ADDRESS_SEQUENCER_Valid_Out,
        output CS_ADDRESS_SEQUENCER_Halt_Out
    );
endinterface

// File: rtl/cs_address_sequencer.sv
// Microprogram sequencer: registers the next control-store address from the branch type,
// with stall hold, a one-cycle post-reset init state and sticky self-loop halt.
module cs_address_sequencer #(
    parameter int unsigned CS_ADDRESS_SEQUENCER_ADDR = 11,
    parameter int unsigned CS_ADDRESS_SEQUENCER_TIPO = 2,
    parameter int unsigned CS_ADDRESS_SEQUENCER_IR   = 32
) (
    input  logic                 CS_ADDRESS_SEQUENCER_CLOCK_50,
    input  logic                 CS_ADDRESS_SEQUENCER_ResetInLow_In,
    cs_address_sequencer_if.slave bus
);
    localparam int unsigned AW = CS_ADDRESS_SEQUENCER_ADDR;
    localparam int unsigned TW = CS_ADDRESS_SEQUENCER_TIPO;
    localparam int unsigned IW = CS_ADDRESS_SEQUENCER_IR;

    localparam logic [TW-1:0] TIPO_JUMP   = TW'(1);
    localparam logic [TW-1:0] TIPO_DECODE = TW'(2);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic          halt_q, halt_d;

    logic [TW-1:0] tipo;
    logic [AW-1:0] jump_addr;
    logic [IW-1:0] ir;
    logic          stall;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] decode_addr;
    logic          unused_ir;

    assign tipo      = bus.CS_ADDRESS_SEQUENCER_Tipo_InBus;
    assign jump_addr = bus.CS_ADDRESS_SEQUENCER_JumpAddr_InBus;
    assign ir        = bus.CS_ADDRESS_SEQUENCER_IR_InBus;
    assign stall     = bus.CS_ADDRESS_SEQUENCER_Stall_In;

    // Decode target: opcode and op3 fields packed into the upper half of the store.
    assign next_addr   = addr_q + AW'(1);
    assign decode_addr = AW'({1'b1, ir[31:30], ir[24:19], 2'b00});
    assign unused_ir   = ^{ir[29:25], ir[18:0]};

    // Next-state and next-output selection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                addr_d  = '0;
                valid_d = 1'b1;
                halt_d  = 1'b0;
            end
            ST_RUN: begin
                valid_d = 1'b1;
                if (!stall) begin
                    if (tipo == TIPO_JUMP && jump_addr == addr_q) begin
                        state_d = ST_HALTED;
                        addr_d  = jump_addr;
                        halt_d  = 1'b1;
                    end else if (tipo == TIPO_JUMP) begin
                        addr_d = jump_addr;
                    end else if (tipo == TIPO_DECODE) begin
                        addr_d = decode_addr;
                    end else begin
                        addr_d = next_addr;
                    end
                end
            end
            ST_HALTED: begin
                valid_d = 1'b1;
                halt_d  = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
                addr_d  = '0;
                valid_d = 1'b0;
                halt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50 or negedge CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
        if (!CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
            state_q <= ST_INIT;
            addr_q  <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus = addr_q;
    assign bus.CS_ADDRESS_SEQUENCER_Valid_Out        = valid_q;
    assign bus.CS_ADDRESS_SEQUENCER_Halt_Out         = halt_q;
endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed bench for cs_address_sequencer: vector table plus hand sequences for reset corners.
module tb_cs_address_sequencer;
    logic clk;
    logic rst_n;

    cs_address_sequencer_if #(
        .CS_ADDRESS_SEQUENCER_ADDR(11),
        .CS_ADDRESS_SEQUENCER_TIPO(2),
        .CS_ADDRESS_SEQUENCER_IR(32)
    ) bus ();

    cs_address_sequencer #(
        .CS_ADDRESS_SEQUENCER_ADDR(11),
        .CS_ADDRESS_SEQUENCER_TIPO(2),
        .CS_ADDRESS_SEQUENCER_IR(32)
    ) dut (
        .CS_ADDRESS_SEQUENCER_CLOCK_50(clk),
        .CS_ADDRESS_SEQUENCER_ResetInLow_In(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  tipo;
        logic [10:0] jump;
        logic [31:0] ir;
        logic        stall;
        logic [10:0] addr;
        logic        valid;
        logic        halt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];
    int n_cmp;
    int n_err;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [10:0] a, input logic v, input logic h);
        check({tag, "_addr"},  idx, 32'(bus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus), 32'(a));
        check({tag, "_valid"}, idx, 32'(bus.CS_ADDRESS_SEQUENCER_Valid_Out), 32'(v));
        check({tag, "_halt"},  idx, 32'(bus.CS_ADDRESS_SEQUENCER_Halt_Out), 32'(h));
    endtask

    task automatic drive(input logic [1:0] t, input logic [10:0] j, input logic [31:0] ir, input logic s);
        bus.CS_ADDRESS_SEQUENCER_Tipo_InBus     = t;
        bus.CS_ADDRESS_SEQUENCER_JumpAddr_InBus = j;
        bus.CS_ADDRESS_SEQUENCER_IR_InBus       = ir;
        bus.CS_ADDRESS_SEQUENCER_Stall_In       = s;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        //           tipo   jump     ir            stall  addr     valid halt
        vecs[0]  = '{2'b00, 11'h000, 32'h0,        1'b0, 11'h000, 1'b1, 1'b0};
        vecs[1]  = '{2'b00, 11'h000, 32'h0,        1'b0, 11'h001, 1'b1, 1'b0};
        vecs[2]  = '{2'b00, 11'h000, 32'h0,        1'b0, 11'h002, 1'b1, 1'b0};
        vecs[3]  = '{2'b01, 11'h7FF, 32'h0,        1'b0, 11'h7FF, 1'b1, 1'b0};
        vecs[4]  = '{2'b00, 11'h000, 32'h0,        1'b0, 11'h000, 1'b1, 1'b0};
        vecs[5]  = '{2'b01, 11'h005, 32'h0,        1'b0, 11'h005, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 11'h000, 32'h82000000, 1'b0, 11'h600, 1'b1, 1'b0};
        vecs[7]  = '{2'b01, 11'h005, 32'h0,        1'b0, 11'h005, 1'b1, 1'b0};
        vecs[8]  = '{2'b10, 11'h000, 32'hC0200000, 1'b0, 11'h710, 1'b1, 1'b0};
        vecs[9]  = '{2'b01, 11'h007, 32'h0,        1'b0, 11'h007, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 11'h123, 32'h0,        1'b1, 11'h007, 1'b1, 1'b0};
        vecs[11] = '{2'b01, 11'h123, 32'h0,        1'b1, 11'h007, 1'b1, 1'b0};
        vecs[12] = '{2'b01, 11'h123, 32'h0,        1'b0, 11'h123, 1'b1, 1'b0};
        vecs[13] = '{2'b01, 11'h009, 32'h0,        1'b0, 11'h009, 1'b1, 1'b0};
        vecs[14] = '{2'b11, 11'h000, 32'h0,        1'b0, 11'h00A, 1'b1, 1'b0};
        vecs[15] = '{2'b01, 11'h00A, 32'h0,        1'b1, 11'h00A, 1'b1, 1'b0};
        vecs[16] = '{2'b01, 11'h040, 32'h0,        1'b0, 11'h040, 1'b1, 1'b0};
        vecs[17] = '{2'b01, 11'h040, 32'h0,        1'b0, 11'h040, 1'b1, 1'b1};
        vecs[18] = '{2'b00, 11'h000, 32'h0,        1'b0, 11'h040, 1'b1, 1'b1};
        vecs[19] = '{2'b10, 11'h000, 32'hC0200000, 1'b0, 11'h040, 1'b1, 1'b1};
        vecs[20] = '{2'b01, 11'h100, 32'h0,        1'b0, 11'h040, 1'b1, 1'b1};

        rst_n = 1'b0;
        drive(2'b00, 11'h000, 32'h0, 1'b0);
        #12;
        check_all("reset", 0, 11'h000, 1'b0, 1'b0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_all("init", 0, 11'h000, 1'b0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].tipo, vecs[i].jump, vecs[i].ir, vecs[i].stall);
            @(posedge clk); #1;
            check_all("vec", i, vecs[i].addr, vecs[i].valid, vecs[i].halt);
        end

        // Asynchronous reset from HALTED, mid-cycle.
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_halted", 0, 11'h000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all("held_reset", 0, 11'h000, 1'b0, 1'b0);

        // INIT ignores stall and tipo.
        drive(2'b01, 11'h033, 32'h0, 1'b1);
        rst_n = 1'b1;
        #1;
        check_all("init2", 0, 11'h000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all("init_ignore", 0, 11'h000, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_all("run_stall", 0, 11'h000, 1'b1, 1'b0);
        drive(2'b01, 11'h033, 32'h0, 1'b0);
        @(posedge clk); #1;
        check_all("run_jump", 0, 11'h033, 1'b1, 1'b0);

        // Asynchronous reset during a stall.
        drive(2'b00, 11'h000, 32'h0, 1'b1);
        @(posedge clk); #1;
        check_all("stall_hold", 0, 11'h033, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_stall", 0, 11'h000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cs_address_sequencer.md
Name: cs_address_sequencer

Overview:
- Microprogram sequencer directly downstream of the branch logic stage.
- Consumes the 2-bit branch type (00 next, 01 jump, 10 decode) each cycle and the MIR jump-address field, and registers the next control-store address (microPC) driving the control store.
- Adds stall hold, post-reset init cycle, and self-loop halt detection.

Parameters:
- CS_ADDRESS_SEQUENCER_ADDR, 11, control-store address width (2048 words).
- CS_ADDRESS_SEQUENCER_TIPO, 2, branch type width.
- CS_ADDRESS_SEQUENCER_IR, 32, instruction register width.

Ports:
- CS_ADDRESS_SEQUENCER_CLOCK_50  input  1  system clock, rising edge.
- CS_ADDRESS_SEQUENCER_ResetInLow_In  input  1  asynchronous reset, active low.
- CS_ADDRESS_SEQUENCER_Tipo_InBus  input  TIPO  branch type from branch logic.
- CS_ADDRESS_SEQUENCER_JumpAddr_InBus  input  ADDR  MIR jump-address field.
- CS_ADDRESS_SEQUENCER_IR_InBus  input  IR  current instruction register.
- CS_ADDRESS_SEQUENCER_Stall_In  input  1  hold microPC this cycle.
- CS_ADDRESS_SEQUENCER_CSAddress_OutBus  output  ADDR  registered microPC to control store.
- CS_ADDRESS_SEQUENCER_Valid_Out  output  1  microPC holds a sequenced (non-init) address.
- CS_ADDRESS_SEQUENCER_Halt_Out  output  1  sticky self-loop halt flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While ResetInLow_In=0: CSAddress=0, Valid=0, Halt=0, state=INIT. Deassertion is taken synchronously at the next rising edge.
- Next-address candidates (combinational, ADDR bits):
  - NEXT = CSAddress+1, modulo 2^ADDR (2047 wraps to 0).
  - JUMP = JumpAddr_InBus.
  - DECODE = {1'b1, IR[31:30], IR[24:19], 2'b00}, for ADDR=11.
  - Tipo 2'b11 is reserved and is treated as NEXT.
- States: INIT, RUN, HALTED.
- INIT:
  - Exactly one cycle after reset release; CSAddress stays 0, Valid=0.
  - Tipo and Stall are ignored.
  - Next state is RUN. The first RUN cycle presents address 0 with Valid=1.
- RUN, each rising edge:
  - If Stall_In=1: CSAddress holds and Tipo is ignored. Stall has priority over every Tipo value.
  - Otherwise CSAddress takes the candidate selected by Tipo.
  - Valid=1 throughout RUN.
- Halt detect (RUN, Stall=0): Tipo=01 and JumpAddr==CSAddress -> load JumpAddr, move to HALTED, and assert Halt_Out at that same edge.
- HALTED:
  - CSAddress frozen; Valid=1; Halt_Out=1.
  - All inputs ignored.
  - Exit only via reset.
- Latency: the address selected in cycle N appears on CSAddress_OutBus after edge N+1. There is no combinational path from inputs to outputs.
- All outputs are registered.
- Reset asserted mid-operation, including in HALTED or during a stall, forces the reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset release, Tipo=00, Stall=0 -> cycle 1 addr 0 Valid=0; cycle 2 addr 0 Valid=1; cycles 3,4 addr 1,2.
- Preload addr 2047 via jump, then Tipo=00 -> addr wraps to 0, Halt=0.
- From addr 5: Tipo=10 with IR=0x8200_0000 (op=10, op3=000000) -> addr 0x600. Repeat with IR op=11, op3=000100 -> addr 0x710.
- Addr 7, Tipo=01, JumpAddr=0x123 with Stall=1 for 2 cycles -> addr stays 7. Release stall -> addr 0x123.
- Addr 0x040, Tipo=01, JumpAddr=0x040 -> Halt=1 next edge. Subsequent Tipo=00/10 leave addr 0x040. Reset low mid-cycle -> addr 0, Halt=0, Valid=0 without waiting for a clock edge.
- Tipo=11 at addr 9 -> addr 10.
